// File: rtl/reg_40xx_wr_port_ctrl_pkg.sv
// Shared constants, state encoding and a small modulo-3 helper for the
// 40-entry register file write-port controller.
package reg_40xx_wr_port_ctrl_pkg;

  localparam int NUM_ENTRIES = 40;
  localparam int ADDR_W      = 6;
  localparam int NUM_REQ     = 3;

  // Highest legal entry address; also the final address of the clear walk.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Reduce a value in 0..5 to 0..2 (one conditional subtract of 3).
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    logic [2:0] t;
    t = (v >= 3'd3) ? v - 3'd3 : v;
    return t[1:0];
  endfunction

endpackage

// File: rtl/reg_40xx_wr_port_ctrl_rr_arb.sv
// Three-way round-robin arbiter: grants the first requesting index at or
// after ptr, wrapping modulo 3. Purely combinational.
module rr_arb_3
  import reg_40xx_wr_port_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         gnt_idx
);

  logic [1:0] ptr_s;
  logic [1:0] idx;
  logic       found;

  // ptr value 3 is unused; treat it as 0 so the search order stays defined.
  assign ptr_s = (ptr == 2'd3) ? 2'd0 : ptr;

  // Scan ptr, ptr+1, ptr+2 (mod 3) and take the first set request.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = wrap3({1'b0, ptr_s} + 3'(k));
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gnt_idx    = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_40xx_wr_port_ctrl.sv
// Write-port controller for a 40-entry register file: shares the single
// write port between three requesters and runs a hardware zero-clear walk.
module reg_40xx_wr_port_ctrl
  import reg_40xx_wr_port_ctrl_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_req,
  output logic                       clear_busy,
  input  logic [NUM_REQ-1:0]         req_en,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       addr_err,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [WIDTH-1:0]           wr_data
);

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [1:0]         rr_ptr;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         gnt_idx;
  logic               grant_valid;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [WIDTH-1:0]   gnt_data;
  logic               addr_ok;
  logic               clear_last;

  // Requests only compete while idle; a clear request in the same cycle wins.
  assign arb_req     = (state == ST_IDLE && !clear_req && !rst) ? req_en : '0;
  assign grant_valid = |grant;
  assign req_ack     = grant;
  assign clear_busy  = (state == ST_CLEAR);
  assign clear_last  = (clr_cnt == LAST_ADDR);
  assign addr_ok     = (gnt_addr <= LAST_ADDR);

  rr_arb_3 u_arb (
    .req     (arb_req),
    .ptr     (rr_ptr),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  // Select the winning requester's address and data.
  always_comb begin
    gnt_addr = req_addr[ADDR_W-1:0];
    gnt_data = req_data[WIDTH-1:0];
    case (gnt_idx)
      2'd1: begin
        gnt_addr = req_addr[2*ADDR_W-1:ADDR_W];
        gnt_data = req_data[2*WIDTH-1:WIDTH];
      end
      2'd2: begin
        gnt_addr = req_addr[3*ADDR_W-1:2*ADDR_W];
        gnt_data = req_data[3*WIDTH-1:2*WIDTH];
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: enter CLEAR on request, leave after issuing the last entry.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clear_req)  state_nxt = ST_CLEAR;
      ST_CLEAR: if (clear_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Write-port registers, clear counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      addr_err <= 1'b0;
      clr_cnt  <= '0;
      rr_ptr   <= '0;
    end else if (state == ST_CLEAR) begin
      wr_en    <= 1'b1;
      wr_addr  <= clr_cnt;
      wr_data  <= '0;
      addr_err <= 1'b0;
      clr_cnt  <= clear_last ? '0 : clr_cnt + 1'b1;
    end else if (grant_valid) begin
      rr_ptr <= wrap3({1'b0, gnt_idx} + 3'd1);
      if (addr_ok) begin
        wr_en    <= 1'b1;
        wr_addr  <= gnt_addr;
        wr_data  <= gnt_data;
        addr_err <= 1'b0;
      end else begin
        wr_en    <= 1'b0;
        addr_err <= 1'b1;
      end
    end else begin
      wr_en    <= 1'b0;
      addr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_40xx_wr_port_ctrl.sv
// Self-checking bench for reg_40xx_wr_port_ctrl: directed scenarios with
// literal expectations plus a cycle-by-cycle behavioural model.
module tb_reg_40xx_wr_port_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           clear_req;
  logic           clear_busy;
  logic [2:0]     req_en;
  logic [17:0]    req_addr;
  logic [3*W-1:0] req_data;
  logic [2:0]     req_ack;
  logic           addr_err;
  logic           wr_en;
  logic [5:0]     wr_addr;
  logic [W-1:0]   wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  reg_40xx_wr_port_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .req_en     (req_en),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .addr_err   (addr_err),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic [2:0] en,
                               input logic [17:0] addr, input logic [3*W-1:0] data);
    @(posedge clk);
    #1;
    clear_req = clr;
    req_en    = en;
    req_addr  = addr;
    req_data  = data;
  endtask

  // Behavioural model: remaining clear writes, rotating priority, and the
  // write expected to appear on the port in the following cycle.
  int           m_clear_left;
  int           m_ptr;
  logic         exp_wr_en;
  logic [5:0]   exp_wr_addr;
  logic [W-1:0] exp_wr_data;
  logic         exp_addr_err;

  // Compare process: checks every cycle at the falling edge, then advances the model.
  always @(negedge clk) begin
    int         g;
    int         a;
    logic [2:0] exp_ack;
    if (rst) begin
      checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
      checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
      checkOutput("rst_busy", 32'(clear_busy), 32'd0);
      checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
      checkOutput("rst_ack", 32'(req_ack), 32'd0);
      m_clear_left = 0;
      m_ptr        = 0;
      exp_wr_en    = 1'b0;
      exp_wr_addr  = '0;
      exp_wr_data  = '0;
      exp_addr_err = 1'b0;
    end else begin
      checkOutput("model_wr_en", 32'(wr_en), 32'(exp_wr_en));
      checkOutput("model_addr_err", 32'(addr_err), 32'(exp_addr_err));
      if (exp_wr_en) begin
        checkOutput("model_wr_addr", 32'(wr_addr), 32'(exp_wr_addr));
        checkOutput("model_wr_data", 32'(wr_data), 32'(exp_wr_data));
      end
      if (wr_en) checkOutput("model_addr_range", 32'(wr_addr < 6'd40), 32'd1);
      checkOutput("model_busy", 32'(clear_busy), 32'(m_clear_left > 0));
      exp_ack = 3'b000;
      if (m_clear_left > 0) begin
        exp_wr_en    = 1'b1;
        exp_wr_addr  = 6'(40 - m_clear_left);
        exp_wr_data  = '0;
        exp_addr_err = 1'b0;
        m_clear_left = m_clear_left - 1;
      end else if (clear_req) begin
        exp_wr_en    = 1'b0;
        exp_addr_err = 1'b0;
        m_clear_left = 40;
      end else if (req_en != 3'b000) begin
        g = -1;
        for (int k = 0; k < 3; k++) begin
          if (g < 0 && req_en[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        end
        exp_ack = 3'b001 << g;
        m_ptr   = (g + 1) % 3;
        a       = int'(req_addr[6*g +: 6]);
        if (a < 40) begin
          exp_wr_en    = 1'b1;
          exp_wr_addr  = 6'(a);
          exp_wr_data  = req_data[W*g +: W];
          exp_addr_err = 1'b0;
        end else begin
          exp_wr_en    = 1'b0;
          exp_addr_err = 1'b1;
        end
      end else begin
        exp_wr_en    = 1'b0;
        exp_addr_err = 1'b0;
      end
      checkOutput("model_ack", 32'(req_ack), 32'(exp_ack));
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    logic [2:0] ack_seq [6];
    logic [5:0] addr_seq [6];
    int busy_cnt;
    int writes;
    int ack_cycle;

    ack_seq  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    addr_seq = '{6'd10, 6'd11, 6'd12, 6'd10, 6'd11, 6'd12};

    rst       = 1'b1;
    clear_req = 1'b0;
    req_en    = '0;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single request from requester 0.
    @(negedge clk);
    checkOutput("t1_idle_wr_en", 32'(wr_en), 32'd0);
    checkOutput("t1_idle_busy", 32'(clear_busy), 32'd0);
    applyStimulus(1'b0, 3'b001, {6'd0, 6'd0, 6'd5}, {8'h00, 8'h00, 8'hA5});
    @(negedge clk);
    checkOutput("t1_ack", 32'(req_ack), 32'h1);
    applyStimulus(1'b0, 3'b000, '0, '0);
    @(negedge clk);
    checkOutput("t1_wr_en", 32'(wr_en), 32'd1);
    checkOutput("t1_wr_addr", 32'(wr_addr), 32'd5);
    checkOutput("t1_wr_data", 32'(wr_data), 32'hA5);

    // Bring the pointer back to 0, then all three request continuously.
    applyStimulus(1'b0, 3'b100, {6'd30, 6'd0, 6'd0}, {8'h33, 8'h00, 8'h00});
    @(negedge clk);
    checkOutput("t2_ptr_setup_ack", 32'(req_ack), 32'h4);
    applyStimulus(1'b0, 3'b000, '0, '0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 3'b111, {6'd12, 6'd11, 6'd10}, {8'hCC, 8'hBB, 8'hAA});
      @(negedge clk);
      checkOutput("t2_ack", 32'(req_ack), 32'(ack_seq[i]));
      if (i > 0) checkOutput("t2_wr_addr", 32'(wr_addr), 32'(addr_seq[i-1]));
    end
    applyStimulus(1'b0, 3'b000, '0, '0);
    @(negedge clk);
    checkOutput("t2_last_wr_addr", 32'(wr_addr), 32'd12);
    checkOutput("t2_last_wr_data", 32'(wr_data), 32'hCC);
    applyStimulus(1'b0, 3'b000, '0, '0);

    // Full clear with requester 0 waiting throughout.
    applyStimulus(1'b1, 3'b000, '0, '0);
    busy_cnt  = 0;
    writes    = 0;
    ack_cycle = 0;
    for (int c = 1; c <= 50; c++) begin
      applyStimulus(1'b0, 3'b001, {6'd0, 6'd0, 6'd7}, {8'h00, 8'h00, 8'h77});
      @(negedge clk);
      if (clear_busy) busy_cnt++;
      if (wr_en && writes < 40) begin
        checkOutput("t3_clear_addr", 32'(wr_addr), 32'(writes));
        checkOutput("t3_clear_data", 32'(wr_data), 32'd0);
        writes++;
      end
      if (req_ack != 3'b000) begin
        ack_cycle = c;
        break;
      end
    end
    checkOutput("t3_busy_cycles", 32'(busy_cnt), 32'd40);
    checkOutput("t3_writes", 32'(writes), 32'd40);
    checkOutput("t3_ack_cycle", 32'(ack_cycle), 32'd41);
    applyStimulus(1'b0, 3'b000, '0, '0);
    @(negedge clk);
    checkOutput("t3_post_wr_en", 32'(wr_en), 32'd1);
    checkOutput("t3_post_wr_addr", 32'(wr_addr), 32'd7);
    checkOutput("t3_post_wr_data", 32'(wr_data), 32'h77);

    // Clear beats a simultaneous request; a second clear_req is ignored.
    applyStimulus(1'b1, 3'b010, {6'd0, 6'd20, 6'd0}, {8'h00, 8'h44, 8'h00});
    @(negedge clk);
    checkOutput("t4_no_ack", 32'(req_ack), 32'd0);
    busy_cnt = 0;
    writes   = 0;
    for (int c = 1; c <= 45; c++) begin
      applyStimulus(c == 10, 3'b000, '0, '0);
      @(negedge clk);
      if (clear_busy) busy_cnt++;
      if (wr_en) writes++;
    end
    checkOutput("t4_busy_cycles", 32'(busy_cnt), 32'd40);
    checkOutput("t4_writes", 32'(writes), 32'd40);

    // Out-of-range addresses: acked, dropped, error pulse, pointer advances.
    applyStimulus(1'b0, 3'b001, {6'd0, 6'd0, 6'd40}, {8'h00, 8'h00, 8'h11});
    @(negedge clk);
    checkOutput("t5_ack40", 32'(req_ack), 32'h1);
    applyStimulus(1'b0, 3'b010, {6'd0, 6'd63, 6'd0}, {8'h00, 8'h22, 8'h00});
    @(negedge clk);
    checkOutput("t5_err40", 32'(addr_err), 32'd1);
    checkOutput("t5_wr_en40", 32'(wr_en), 32'd0);
    checkOutput("t5_ack63", 32'(req_ack), 32'h2);
    applyStimulus(1'b0, 3'b111, {6'd3, 6'd2, 6'd1}, {8'h03, 8'h02, 8'h01});
    @(negedge clk);
    checkOutput("t5_err63", 32'(addr_err), 32'd1);
    checkOutput("t5_wr_en63", 32'(wr_en), 32'd0);
    checkOutput("t5_ptr_adv_ack", 32'(req_ack), 32'h4);
    applyStimulus(1'b0, 3'b000, '0, '0);
    @(negedge clk);
    checkOutput("t5_err_clear", 32'(addr_err), 32'd0);
    checkOutput("t5_wr_addr", 32'(wr_addr), 32'd3);

    // Reset in the middle of a clear, then a fresh clear from address 0.
    applyStimulus(1'b1, 3'b000, '0, '0);
    repeat (20) applyStimulus(1'b0, 3'b000, '0, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("t6_rst_busy", 32'(clear_busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 3'b000, '0, '0);
    applyStimulus(1'b0, 3'b000, '0, '0);
    @(negedge clk);
    checkOutput("t6_busy", 32'(clear_busy), 32'd1);
    applyStimulus(1'b0, 3'b000, '0, '0);
    @(negedge clk);
    checkOutput("t6_first_wr_en", 32'(wr_en), 32'd1);
    checkOutput("t6_first_addr", 32'(wr_addr), 32'd0);
    applyStimulus(1'b0, 3'b000, '0, '0);
    @(negedge clk);
    checkOutput("t6_second_addr", 32'(wr_addr), 32'd1);
    repeat (45) applyStimulus(1'b0, 3'b000, '0, '0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
